// File: rtl/dmem_arbiter_if.sv
// One requester channel into dmem_arbiter: a beat is accepted on gnt, and read
// data returns on rvalid/rdata the following cycle.
interface dmem_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic          lock;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data BRAM between the CPU (fixed priority) and the
// IPU/ACC DMA engines (round-robin, burst lock, starvation guard).
module dmem_arbiter #(
  parameter int AW           = 11,
  parameter int DW           = 16,
  parameter int BURST_MAX    = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave cpu,
  dmem_arbiter_if.slave ipu,
  dmem_arbiter_if.slave acc,
  output logic          cpu_stall,
  output logic          bram_en,
  output logic          bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_wdata,
  input  logic [DW-1:0] bram_rdata
);

  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {OPEN, LOCK_IPU, LOCK_ACC, COOL} state_t;

  state_t        state;
  logic          rr_acc;
  logic          cool_acc;
  logic [WW-1:0] wait_ipu;
  logic [WW-1:0] wait_acc;
  logic [BW-1:0] beat_cnt;
  logic [2:0]    rvalid_q;

  logic gnt_cpu, gnt_ipu, gnt_acc;
  logic elig_ipu, elig_acc, starve_ipu, starve_acc;

  // A starved DMA engine outranks the CPU; the engine that just finished a
  // full burst sits out the single COOL cycle.
  always_comb begin
    gnt_cpu    = 1'b0;
    gnt_ipu    = 1'b0;
    gnt_acc    = 1'b0;
    elig_ipu   = ipu.req && !(state == COOL && !cool_acc);
    elig_acc   = acc.req && !(state == COOL && cool_acc);
    starve_ipu = elig_ipu && (wait_ipu == WW'(STARVE_LIMIT));
    starve_acc = elig_acc && (wait_acc == WW'(STARVE_LIMIT));
    if (!rst) begin
      if (state == LOCK_IPU)              gnt_ipu = ipu.req;
      else if (state == LOCK_ACC)         gnt_acc = acc.req;
      else if (starve_ipu && starve_acc) begin
        gnt_ipu = !rr_acc;
        gnt_acc = rr_acc;
      end
      else if (starve_ipu)                gnt_ipu = 1'b1;
      else if (starve_acc)                gnt_acc = 1'b1;
      else if (cpu.req)                   gnt_cpu = 1'b1;
      else if (elig_ipu && (!rr_acc || !elig_acc)) gnt_ipu = 1'b1;
      else if (elig_acc)                  gnt_acc = 1'b1;
    end
  end

  always_comb begin
    bram_en    = gnt_cpu | gnt_ipu | gnt_acc;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_wdata = '0;
    if (gnt_cpu) begin
      bram_we    = cpu.we;
      bram_addr  = cpu.addr;
      bram_wdata = cpu.wdata;
    end else if (gnt_ipu) begin
      bram_we    = ipu.we;
      bram_addr  = ipu.addr;
      bram_wdata = ipu.wdata;
    end else if (gnt_acc) begin
      bram_we    = acc.we;
      bram_addr  = acc.addr;
      bram_wdata = acc.wdata;
    end
  end

  assign cpu.gnt    = gnt_cpu;
  assign ipu.gnt    = gnt_ipu;
  assign acc.gnt    = gnt_acc;
  assign cpu_stall  = cpu.req && !gnt_cpu && !rst;

  // rvalid is gated by rst so a read pending at reset never escapes.
  assign cpu.rvalid = rvalid_q[0] && !rst;
  assign ipu.rvalid = rvalid_q[1] && !rst;
  assign acc.rvalid = rvalid_q[2] && !rst;
  assign cpu.rdata  = cpu.rvalid ? bram_rdata : '0;
  assign ipu.rdata  = ipu.rvalid ? bram_rdata : '0;
  assign acc.rdata  = acc.rvalid ? bram_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= OPEN;
      rr_acc   <= 1'b0;
      cool_acc <= 1'b0;
      wait_ipu <= '0;
      wait_acc <= '0;
      beat_cnt <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= {gnt_acc && !acc.we, gnt_ipu && !ipu.we, gnt_cpu && !cpu.we};

      if (gnt_ipu)                                            wait_ipu <= '0;
      else if (ipu.req && wait_ipu != WW'(STARVE_LIMIT))      wait_ipu <= wait_ipu + WW'(1);
      if (gnt_acc)                                            wait_acc <= '0;
      else if (acc.req && wait_acc != WW'(STARVE_LIMIT))      wait_acc <= wait_acc + WW'(1);

      if (gnt_ipu)      rr_acc <= 1'b1;
      else if (gnt_acc) rr_acc <= 1'b0;

      // A dropped lock ends the burst before the length limit is considered.
      case (state)
        LOCK_IPU, LOCK_ACC: begin
          if (!(gnt_ipu || gnt_acc)) begin
            state <= OPEN;
          end else if (!((state == LOCK_IPU) ? ipu.lock : acc.lock)) begin
            state <= OPEN;
          end else if (beat_cnt == BW'(BURST_MAX - 1)) begin
            state    <= COOL;
            cool_acc <= (state == LOCK_ACC);
          end else begin
            beat_cnt <= beat_cnt + BW'(1);
          end
        end
        default: begin
          state <= OPEN;
          if (gnt_ipu && ipu.lock) begin
            state    <= LOCK_IPU;
            beat_cnt <= BW'(1);
          end else if (gnt_acc && acc.lock) begin
            state    <= LOCK_ACC;
            beat_cnt <= BW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a behavioural arbitration model.
module tb_dmem_arbiter;

  localparam int AW           = 11;
  localparam int DW           = 16;
  localparam int BURST_MAX    = 16;
  localparam int STARVE_LIMIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // index 0 = cpu, 1 = ipu, 2 = acc
  logic          req   [3];
  logic          we    [3];
  logic          lock  [3];
  logic [AW-1:0] addr  [3];
  logic [DW-1:0] wdata [3];
  logic          dut_gnt [3];
  logic          dut_rv  [3];
  logic [DW-1:0] dut_rd  [3];

  logic          cpu_stall, bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata, bram_rdata;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) cpu_if ();
  dmem_arbiter_if #(.AW(AW), .DW(DW)) ipu_if ();
  dmem_arbiter_if #(.AW(AW), .DW(DW)) acc_if ();

  assign cpu_if.req = req[0];  assign cpu_if.we = we[0];  assign cpu_if.lock = lock[0];
  assign cpu_if.addr = addr[0]; assign cpu_if.wdata = wdata[0];
  assign ipu_if.req = req[1];  assign ipu_if.we = we[1];  assign ipu_if.lock = lock[1];
  assign ipu_if.addr = addr[1]; assign ipu_if.wdata = wdata[1];
  assign acc_if.req = req[2];  assign acc_if.we = we[2];  assign acc_if.lock = lock[2];
  assign acc_if.addr = addr[2]; assign acc_if.wdata = wdata[2];
  assign dut_gnt[0] = cpu_if.gnt; assign dut_rv[0] = cpu_if.rvalid; assign dut_rd[0] = cpu_if.rdata;
  assign dut_gnt[1] = ipu_if.gnt; assign dut_rv[1] = ipu_if.rvalid; assign dut_rd[1] = ipu_if.rdata;
  assign dut_gnt[2] = acc_if.gnt; assign dut_rv[2] = acc_if.rvalid; assign dut_rd[2] = acc_if.rdata;

  dmem_arbiter #(
    .AW(AW), .DW(DW), .BURST_MAX(BURST_MAX), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu        (cpu_if),
    .ipu        (ipu_if),
    .acc        (acc_if),
    .cpu_stall  (cpu_stall),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .bram_rdata (bram_rdata)
  );

  function automatic logic [DW-1:0] init_val(int a);
    return (a == 16) ? 16'hBEEF : DW'(a * 40503 + 7);
  endfunction

  // BRAM with a one-cycle registered read
  logic [DW-1:0] bram_mem [int];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) bram_mem[int'(bram_addr)] = bram_wdata;
      else bram_rdata <= bram_mem.exists(int'(bram_addr)) ? bram_mem[int'(bram_addr)]
                                                          : init_val(int'(bram_addr));
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: owner of a burst lock (0 = none), beats taken so far,
  // requester benched for one cycle after a full burst, round-robin favourite,
  // wait counts, and the shadow memory contents.
  int            m_owner = 0, m_beats = 0, m_cool = 0, m_rr = 1;
  int            m_wait [3] = '{0, 0, 0};
  int            rd_req = -1, last_g = -1;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] shadow [int];

  function automatic int pick();
    logic elig1, elig2, st1, st2;
    if (rst) return -1;
    if (m_owner != 0) return req[m_owner] ? m_owner : -1;
    elig1 = req[1] && (m_cool != 1);
    elig2 = req[2] && (m_cool != 2);
    st1   = elig1 && (m_wait[1] == STARVE_LIMIT);
    st2   = elig2 && (m_wait[2] == STARVE_LIMIT);
    if (st1 && st2) return m_rr;
    if (st1) return 1;
    if (st2) return 2;
    if (req[0]) return 0;
    if (m_rr == 1) return elig1 ? 1 : (elig2 ? 2 : -1);
    return elig2 ? 2 : (elig1 ? 1 : -1);
  endfunction

  always @(posedge clk) begin
    int g;
    if (rst) begin
      m_owner = 0; m_beats = 0; m_cool = 0; m_rr = 1;
      m_wait  = '{0, 0, 0};
      rd_req  = -1; last_g = -1;
    end else begin
      g      = pick();
      last_g = g;
      rd_req = -1;
      if (g >= 0) begin
        if (we[g]) shadow[int'(addr[g])] = wdata[g];
        else begin
          rd_req  = g;
          rd_data = shadow.exists(int'(addr[g])) ? shadow[int'(addr[g])] : init_val(int'(addr[g]));
        end
      end
      for (int k = 1; k < 3; k++) begin
        if (g == k) m_wait[k] = 0;
        else if (req[k] && m_wait[k] < STARVE_LIMIT) m_wait[k]++;
      end
      if (g == 1 || g == 2) m_rr = 3 - g;
      if (m_owner != 0) begin
        if (g != m_owner) m_owner = 0;
        else begin
          m_beats++;
          if (!lock[m_owner]) m_owner = 0;
          else if (m_beats == BURST_MAX) begin
            m_cool  = m_owner;
            m_owner = 0;
          end
        end
      end else begin
        m_cool = 0;
        if ((g == 1 || g == 2) && lock[g]) begin
          m_owner = g;
          m_beats = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    int   g;
    logic exp_rv;
    g = pick();
    for (int k = 0; k < 3; k++) begin
      exp_rv = !rst && (rd_req == k);
      checkOutput($sformatf("gnt[%0d]", k), int'(dut_gnt[k]), int'(g == k));
      checkOutput($sformatf("rvalid[%0d]", k), int'(dut_rv[k]), int'(exp_rv));
      checkOutput($sformatf("rdata[%0d]", k), int'(dut_rd[k]), exp_rv ? int'(rd_data) : 0);
    end
    checkOutput("cpu_stall", int'(cpu_stall), int'(!rst && req[0] && g != 0));
    checkOutput("bram_en", int'(bram_en), int'(g >= 0));
    checkOutput("bram_we", int'(bram_we), (g >= 0) ? int'(we[g]) : 0);
    checkOutput("bram_addr", int'(bram_addr), (g >= 0) ? int'(addr[g]) : 0);
    checkOutput("bram_wdata", int'(bram_wdata), (g >= 0) ? int'(wdata[g]) : 0);
  end

  task automatic applyStimulus(input int k, input logic r, input logic w, input logic l,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[k] = r; we[k] = w; lock[k] = l; addr[k] = a; wdata[k] = d;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) applyStimulus(k, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) nextCycle();
    rst = 1'b0;
  endtask

  int   remaining [3];
  logic active    [3];
  logic burst_lk  [3];

  task automatic newBeat(input int k);
    we[k]    = 1'($urandom_range(0, 1));
    addr[k]  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 2047)) : AW'($urandom_range(0, 15));
    wdata[k] = DW'($urandom);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) applyStimulus(k, 1'b0, 1'b0, 1'b0, '0, '0);
    doReset();

    // cpu read of a preloaded word
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 11'h010, 16'h0);
    @(negedge clk); checkOutput("t1 cpu_gnt", int'(dut_gnt[0]), 1);
    nextCycle(); applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("t1 cpu_rvalid", int'(dut_rv[0]), 1);
    checkOutput("t1 cpu_rdata", int'(dut_rd[0]), 'hBEEF);
    checkOutput("t1 acc_rvalid", int'(dut_rv[2]), 0);
    nextCycle();

    // ipu/acc alternate, ipu first
    doReset();
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 11'h020, 16'h0);
    applyStimulus(2, 1'b1, 1'b0, 1'b0, 11'h021, 16'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t2 ipu_gnt %0d", i), int'(dut_gnt[1]), int'(i % 2 == 0));
      checkOutput($sformatf("t2 acc_gnt %0d", i), int'(dut_gnt[2]), int'(i % 2 == 1));
      nextCycle();
    end

    // locked acc burst capped at BURST_MAX, ipu slips into the COOL cycle
    doReset();
    applyStimulus(2, 1'b1, 1'b0, 1'b1, 11'h040, 16'h0);
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t3 acc_gnt %0d", i), int'(dut_gnt[2]), int'(i != 16));
      checkOutput($sformatf("t3 ipu_gnt %0d", i), int'(dut_gnt[1]), int'(i == 16));
      nextCycle();
      if (i == 0)  applyStimulus(1, 1'b1, 1'b1, 1'b0, 11'h041, 16'h5A5A);
      if (i == 16) applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, '0);
    end
    applyStimulus(2, 1'b0, 1'b0, 1'b0, '0, '0);

    // starvation guard preempts a continuously requesting cpu
    doReset();
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 11'h005, 16'h0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 11'h006, 16'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t4 cpu_gnt %0d", i), int'(dut_gnt[0]), int'(i != 8));
      checkOutput($sformatf("t4 ipu_gnt %0d", i), int'(dut_gnt[1]), int'(i == 8));
      checkOutput($sformatf("t4 cpu_stall %0d", i), int'(cpu_stall), int'(i == 8));
      nextCycle();
      if (i == 8) applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, '0);
    end
    applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0);

    // reset in the middle of a locked ipu read burst
    doReset();
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 11'h030, 16'h0);
    repeat (3) begin
      @(negedge clk); checkOutput("t5 ipu_gnt pre", int'(dut_gnt[1]), 1);
      nextCycle();
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5 ipu_gnt in rst", int'(dut_gnt[1]), 0);
    checkOutput("t5 ipu_rvalid in rst", int'(dut_rv[1]), 0);
    checkOutput("t5 bram_en in rst", int'(bram_en), 0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("t5 ipu_gnt post", int'(dut_gnt[1]), 0);
    checkOutput("t5 ipu_rvalid post", int'(dut_rv[1]), 0);
    checkOutput("t5 bram_en post", int'(bram_en), 0);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 11'h031, 16'h0);
    @(negedge clk); checkOutput("t5 cpu_gnt post", int'(dut_gnt[0]), 1);
    nextCycle();

    // cpu write then read back at the top address
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 11'h7FF, 16'h1234);
    @(negedge clk);
    checkOutput("t6 wr cpu_gnt", int'(dut_gnt[0]), 1);
    checkOutput("t6 wr bram_we", int'(bram_we), 1);
    checkOutput("t6 wr bram_addr", int'(bram_addr), 'h7FF);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 11'h7FF, 16'h0);
    @(negedge clk);
    checkOutput("t6 rd cpu_gnt", int'(dut_gnt[0]), 1);
    checkOutput("t6 rd bram_we", int'(bram_we), 0);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("t6 cpu_rvalid", int'(dut_rv[0]), 1);
    checkOutput("t6 cpu_rdata", int'(dut_rd[0]), 'h1234);
    nextCycle();

    // random traffic; requests held until granted, DMA bursts with locks
    $display("[TB] random phase");
    doReset();
    for (int k = 0; k < 3; k++) begin
      active[k] = 1'b0; remaining[k] = 0; burst_lk[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = (cyc % 1000 == 999);
      for (int k = 0; k < 3; k++) begin
        logic pause;
        pause = 1'b0;
        if (active[k] && last_g == k) begin
          remaining[k]--;
          if (remaining[k] == 0) active[k] = 1'b0;
          else begin
            newBeat(k);
            pause = burst_lk[k] && ($urandom_range(0, 9) == 0);
          end
        end
        if (!active[k] && ((k == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0))) begin
          active[k]    = 1'b1;
          remaining[k] = (k == 0) ? 1 : int'($urandom_range(1, 20));
          burst_lk[k]  = (k != 0) && ($urandom_range(0, 1) == 1);
          newBeat(k);
        end
        req[k]  = active[k] && !pause;
        lock[k] = active[k] && burst_lk[k] && (remaining[k] > 1 || $urandom_range(0, 3) == 0);
      end
      nextCycle();
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(k, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
